// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder and the core control unit that sequences it.
// Holds the responder state encoding, bus widths and default sizing constants.
package core101_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam int          DEFAULT_DEPTH_WORDS  = 1024;
    localparam int          DEFAULT_READ_LATENCY = 1;
    localparam logic [31:0] DEFAULT_BASE_ADDR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } mem_resp_state_e;

    // Merge a new word into an old one, taking only the enabled byte lanes.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_dat,
        input logic [DATA_W-1:0] new_dat,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_dat;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_dat[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised storage: byte-masked synchronous write, registered read captured when rd_en is high.
// Read data appears the cycle after rd_en and holds until the next read; no backpressure.
module data_mem_array
    import core101_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_dat_q;
    logic [DATA_W-1:0] rd_dat_d;
    logic [DATA_W-1:0] wr_word_d;

    always_comb begin
        rd_dat_d  = rd_en ? mem_q[rd_idx] : rd_dat_q;
        wr_word_d = merge_bytes(mem_q[wr_idx], wr_dat, wr_be);
    end

    // Storage is deliberately not reset; contents survive a responder reset.
    always_ff @(posedge clk) begin
        rd_dat_q <= rd_dat_d;
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: decodes core addresses, serves byte-masked writes and word reads onto a shared bus.
// Writes complete at acceptance; reads drive the bus READ_LATENCY cycles later; ready is low while a read is in flight.
module data_mem_responder
    import core101_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = DEFAULT_DEPTH_WORDS,
    parameter int          READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic              mem_resp_clock_in,
    input  logic              mem_resp_reset_in,
    input  logic [31:0]       mem_resp_addr_in,
    inout  wire  [DATA_W-1:0] mem_resp_data_inout,
    input  logic              mem_resp_rd_en_in,
    input  logic              mem_resp_wr_en_in,
    input  logic [BE_W-1:0]   mem_resp_byte_en_in,
    output logic              mem_resp_ready_out,
    output logic              mem_resp_valid_out,
    output logic              mem_resp_error_out
);

    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_M1 = 4'(READ_LATENCY - 1);

    mem_resp_state_e state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_err_q, rd_err_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            error_q, error_d;

    logic [32:0]       offset;
    logic              in_range;
    logic [IDX_W-1:0]  word_idx;
    logic              arr_rd_en;
    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_rd_dat;
    logic [DATA_W-1:0] bus_out_dat;

    // Bit 32 is the borrow, set when the address lies below the base.
    assign offset   = {1'b0, mem_resp_addr_in} - {1'b0, BASE_ADDR};
    assign in_range = !offset[32] && (offset[31:0] < SPAN);
    assign word_idx = offset[IDX_W+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_err_d  = rd_err_q;
        error_d   = 1'b0;
        arr_rd_en = 1'b0;
        arr_wr_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_resp_rd_en_in && !mem_resp_wr_en_in) begin
                    arr_rd_en = in_range;
                    rd_err_d  = !in_range;
                    if (READ_LATENCY == 1) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end else if (mem_resp_wr_en_in && !mem_resp_rd_en_in) begin
                    arr_wr_en = in_range && mem_resp_reset_in;
                    error_d   = !in_range;
                end else if (mem_resp_rd_en_in && mem_resp_wr_en_in) begin
                    error_d = 1'b1;
                end
            end
            // The counter reaches zero on the same edge that enters DRIVE.
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DRIVE;
                end
            end
            DRIVE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DRIVE);
        error_d = error_d || (valid_d && rd_err_d);
    end

    always_ff @(posedge mem_resp_clock_in) begin
        if (!mem_resp_reset_in) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rd_err_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_err_q <= rd_err_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk    (mem_resp_clock_in),
        .wr_en  (arr_wr_en),
        .wr_idx (word_idx),
        .wr_be  (mem_resp_byte_en_in),
        .wr_dat (mem_resp_data_inout),
        .rd_en  (arr_rd_en),
        .rd_idx (word_idx),
        .rd_dat (arr_rd_dat)
    );

    // Out-of-range reads return zero rather than whatever the array last held.
    assign bus_out_dat         = rd_err_q ? '0 : arr_rd_dat;
    assign mem_resp_data_inout = valid_q ? bus_out_dat : {DATA_W{1'bz}};

    assign mem_resp_ready_out = ready_q;
    assign mem_resp_valid_out = valid_q;
    assign mem_resp_error_out = error_q;

endmodule
